loop_burst_arb: RTL and testbench
=================================

// Module: loop_burst_arb
// PURPOSE
//  Burst-level LRU arbiter + datapath mux sharing one downstream valid/ready channel among REQ_NUM requesters.
//  Grant is held for a whole burst (ends on accepted last beat or MAX_BEATS cap).
//  The granted port then drops to lowest priority.
//  Sits between requester ports and a shared sink (bus/FIFO); datapath mux is internal.
// PARAMETERS
//  REQ_NUM    7   number of requester ports (>=2)
//  DW         32  data width per port
//  MAX_BEATS  16  burst length cap forcing release; 0 = unlimited
//  (localparam W = $clog2(REQ_NUM): id width; CW = $clog2(MAX_BEATS+1): beat counter width)
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  arb_en         in   1           enables new grants; does not abort an active burst
//  in_valid       in   REQ_NUM     per-port beat valid / request
//  in_last        in   REQ_NUM     per-port last beat of burst
//  in_data        in   REQ_NUM*DW  per-port data, port i at [i*DW +: DW]
//  in_ready       out  REQ_NUM     per-port ready; only granted bit can be 1
//  out_valid      out  1           shared channel valid
//  out_last       out  1           shared channel last
//  out_data       out  DW          shared channel data
//  out_ready      in   1           sink ready
//  grant          out  REQ_NUM     registered one-hot grant, 0 when idle
//  out_id         out  W           index of granted port, 0 when idle
//  busy           out  1           1 in BUSY state
//  forced_release out  1           1-cycle pulse when MAX_BEATS cap ends a burst
// BEHAVIOUR
//  Reset: grant=0, out_id=0, busy=0, forced_release=0, beat_cnt=0, state=IDLE.
//  Reset priority list: pos0..posN-1 = port 0..N-1; pos0 is highest.
//  Async reset mid-burst: all state returns to reset values at once; the burst is dropped.
//  FSM IDLE:
//   if arb_en && |in_valid: winner = first valid port in priority list.
//   Next edge: grant<=onehot(winner), out_id<=winner, state<=BUSY.
//   Latency: in_valid seen at edge t -> grant/out_valid visible after edge t+1.
//  FSM BUSY:
//   out_valid=in_valid[g], out_last=in_last[g], out_data=in_data[g]  (combinational mux on registered grant g)
//   in_ready[g]=out_ready; all other in_ready bits 0.
//   All in_ready bits are 0 in IDLE.
//   beat = out_valid & out_ready; beat_cnt += 1 per beat.
//   Release on a beat with out_last, or a beat when beat_cnt==MAX_BEATS-1 (MAX_BEATS!=0).
//   A cap-triggered release asserts forced_release for 1 cycle after the edge.
//   If both conditions hit, release normally; forced_release=0.
//   On release edge: grant<=0, out_id<=0, beat_cnt<=0, state<=IDLE.
//   Priority list: g removed from its position, entries below shift up, g appended at posN-1.
//   One mandatory idle cycle between bursts.
//  Priority updates only on release, never on grant.
//  The list stays a permutation of 0..N-1.
//  Grantee deasserting in_valid mid-burst: grant held indefinitely (no timeout); out_valid=0.
//  out_ready=0: beat_cnt frozen, grant held; requester must keep data stable (AXI-style rule).
//  arb_en low during BUSY: current burst runs to release, then no new grant until arb_en=1.
//  Non-granted in_valid/in_last/in_data ignored; no combinational path from in_valid to grant.
//  beat_cnt saturating-free: cleared on release, so it never exceeds MAX_BEATS-1.
// TESTING
//  1. Reset, then idle for 10 cycles.
//     -> grant=0, in_ready=0, out_valid=0, busy=0 throughout.
//  2. Port 3 sends 4 beats, last on beat 4, out_ready=1.
//     -> grant=0b0001000 from cycle t+1; 4 beats on out_data; grant=0 after beat 4.
//     -> Port 3 is now lowest priority.
//  3. All 7 ports hold 1-beat bursts.
//     -> grant order 0,1,2,3,4,5,6,0, one grant every 2 cycles; no port starved.
//  4. MAX_BEATS=16; port 2 streams 20 beats with no last.
//     -> release after beat 16; forced_release pulses once.
//     -> A pending port 5 is granted next; port 2 needs a re-grant for its remaining 4 beats.
//  5. out_ready toggles 1,0,0,1 during a burst.
//     -> out_valid held, beat_cnt frozen while low.
//     -> Exact beat count accepted; in_ready tracks out_ready only on the granted bit.
//  6. Case A: arb_en=0 mid-burst with port 1 valid.
//     -> Burst completes; port 1 is not granted until arb_en=1.
//     Case B: rst_n low mid-burst.
//     -> All outputs 0 immediately; priority returns to 0>1>..>6.

Source files
------------

// File: rtl/loop_burst_arb_if.sv
// Requester-side and sink-side valid/ready handshake bundle for loop_burst_arb.
// slave = arbiter view, master = the requesters/sink (or a testbench) view.
interface loop_burst_arb_if #(
  parameter int REQ_NUM = 7,
  parameter int DW      = 32
);
  logic [REQ_NUM-1:0]    in_valid;
  logic [REQ_NUM-1:0]    in_last;
  logic [REQ_NUM*DW-1:0] in_data;
  logic [REQ_NUM-1:0]    in_ready;
  logic                  out_valid;
  logic                  out_last;
  logic [DW-1:0]         out_data;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data
  );

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data
  );
endinterface

// File: rtl/loop_burst_arb.sv
// Burst-level LRU arbiter with internal datapath mux onto one valid/ready channel.
// A grant lasts a whole burst; the released port moves to the bottom of the priority list.
module loop_burst_arb #(
  parameter int REQ_NUM   = 7,
  parameter int DW        = 32,
  parameter int MAX_BEATS = 16,
  localparam int W        = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int CW       = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_en,
  loop_burst_arb_if.slave    bus,
  output logic [REQ_NUM-1:0] grant,
  output logic [W-1:0]       out_id,
  output logic               busy,
  output logic               forced_release
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [CW-1:0] CAP_LAST = (MAX_BEATS > 0) ? CW'(MAX_BEATS - 1) : '0;

  state_e             state_q, state_d;
  logic [REQ_NUM-1:0] grant_q, grant_d;
  logic [W-1:0]       id_q, id_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               forced_q, forced_d;
  logic [W-1:0]       prio_q [REQ_NUM];
  logic [W-1:0]       prio_d [REQ_NUM];

  logic               win_found;
  logic [W-1:0]       win_id;
  logic [W-1:0]       pos_g;
  logic               beat, last_hit, cap_hit;

  // Datapath mux keyed only by the registered grant, so in_valid never reaches grant combinationally.
  assign bus.out_valid = (state_q == BUSY) && bus.in_valid[id_q];
  assign bus.out_last  = (state_q == BUSY) && bus.in_last[id_q];
  assign bus.out_data  = (state_q == BUSY) ? bus.in_data[int'(id_q)*DW +: DW] : '0;
  assign bus.in_ready  = grant_q & {REQ_NUM{bus.out_ready}};

  assign beat     = bus.out_valid && bus.out_ready;
  assign last_hit = beat && bus.out_last;
  assign cap_hit  = (MAX_BEATS > 0) && beat && (cnt_q == CAP_LAST);

  assign grant          = grant_q;
  assign out_id         = id_q;
  assign busy           = (state_q == BUSY);
  assign forced_release = forced_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latch).
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    forced_d  = 1'b0;
    prio_d    = prio_q;
    win_found = 1'b0;
    win_id    = '0;
    pos_g     = '0;

    // Scan lowest priority first so the highest-priority valid port is the last one written.
    for (int p = REQ_NUM - 1; p >= 0; p--) begin
      if (bus.in_valid[prio_q[p]]) begin
        win_found = 1'b1;
        win_id    = prio_q[p];
      end
    end

    for (int p = 0; p < REQ_NUM; p++) begin
      if (prio_q[p] == id_q) pos_g = W'(p);
    end

    unique case (state_q)
      IDLE: begin
        if (arb_en && win_found) begin
          state_d = BUSY;
          grant_d = REQ_NUM'(1) << win_id;
          id_d    = win_id;
        end
      end
      BUSY: begin
        if (last_hit || cap_hit) begin
          state_d  = IDLE;
          grant_d  = '0;
          id_d     = '0;
          cnt_d    = '0;
          forced_d = cap_hit && !last_hit;
          // Released port leaves its slot, entries below move up, it goes to the bottom.
          for (int p = 0; p < REQ_NUM - 1; p++) begin
            if (p >= int'(pos_g)) prio_d[p] = prio_q[p+1];
          end
          prio_d[REQ_NUM-1] = id_q;
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      forced_q <= 1'b0;
      // NOTE: the priority list is control state that must restart as 0..N-1, so every entry is reset.
      for (int p = 0; p < REQ_NUM; p++) prio_q[p] <= W'(p);
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values whatever the statement order.
      state_q  <= state_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
      prio_q   <= prio_d;
    end
  end

endmodule

// File: tb/tb_loop_burst_arb.sv
// Directed bench for loop_burst_arb: grant latency, LRU order, beat cap, backpressure,
// arb_en gating and asynchronous reset, all against hand-computed expectations.
module tb_loop_burst_arb;
  localparam int N  = 7;
  localparam int DW = 32;
  localparam int MB = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         arb_en;
  logic [N-1:0] grant;
  logic [2:0]   out_id;
  logic         busy;
  logic         forced_release;

  int n_cmp = 0;
  int n_bad = 0;

  loop_burst_arb_if #(.REQ_NUM(N), .DW(DW)) bus ();

  loop_burst_arb #(.REQ_NUM(N), .DW(DW), .MAX_BEATS(MB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arb_en         (arb_en),
    .bus            (bus),
    .grant          (grant),
    .out_id         (out_id),
    .busy           (busy),
    .forced_release (forced_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic v, input logic l, input logic [DW-1:0] d);
    bus.in_valid[i]          = v;
    bus.in_last[i]           = l;
    bus.in_data[i*DW +: DW]  = d;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 64'(grant), 64'(0));
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    rst_n         = 1'b0;
    arb_en        = 1'b0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    check_idle("rst");
    check("rst_out_id", 64'(out_id), 64'(0));
    check("rst_forced", 64'(forced_release), 64'(0));
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    arb_en        = 1'b1;
    bus.out_ready = 1'b1;

    // 1: idle for 10 cycles
    for (int c = 0; c < 10; c++) begin
      step();
      check_idle("t1");
    end

    // 2: port 3, 4-beat burst; grant must not appear combinationally
    set_port(3, 1'b1, 1'b0, 32'hA0);
    #1;
    check("t2_no_comb_grant", 64'(grant), 64'(0));
    check("t2_no_comb_ready", 64'(bus.in_ready), 64'(0));
    step();
    check("t2_grant", 64'(grant), 64'h08);
    check("t2_out_id", 64'(out_id), 64'(3));
    check("t2_busy", 64'(busy), 64'(1));
    for (int k = 0; k < 4; k++) begin
      set_port(3, 1'b1, (k == 3), 32'(32'hA0 + k));
      #1;
      check("t2_out_valid", 64'(bus.out_valid), 64'(1));
      check("t2_out_data", 64'(bus.out_data), 64'(32'hA0 + k));
      check("t2_out_last", 64'(bus.out_last), 64'(k == 3));
      check("t2_in_ready", 64'(bus.in_ready), 64'h08);
      step();
    end
    check("t2_rel_grant", 64'(grant), 64'(0));
    check("t2_rel_busy", 64'(busy), 64'(0));
    check("t2_rel_forced", 64'(forced_release), 64'(0));
    // list now 0,1,2,4,5,6,3: port 6 must beat port 3
    set_port(3, 1'b1, 1'b1, 32'h33);
    set_port(6, 1'b1, 1'b1, 32'h66);
    step();
    check("t2_lru_grant", 64'(grant), 64'h40);
    check("t2_lru_data", 64'(bus.out_data), 64'h66);
    step();
    set_port(3, 1'b0, 1'b0, 32'h0);
    set_port(6, 1'b0, 1'b0, 32'h0);
    check_idle("t2_end");

    // 3: reset to the default list, then all ports hold 1-beat bursts
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_port(i, 1'b1, 1'b1, 32'(32'h100 + i));
    for (int g = 0; g < 8; g++) begin
      step();
      check("t3_grant", 64'(grant), 64'(1 << (g % N)));
      check("t3_data", 64'(bus.out_data), 64'(32'h100 + (g % N)));
      step();
      check("t3_gap", 64'(grant), 64'(0));
    end
    for (int i = 0; i < N; i++) set_port(i, 1'b0, 1'b0, 32'h0);

    // 4: list is 1..6,0; port 2 streams past the cap while port 5 waits
    set_port(2, 1'b1, 1'b0, 32'h200);
    set_port(5, 1'b1, 1'b1, 32'h500);
    step();
    check("t4_grant2", 64'(grant), 64'h04);
    for (int k = 0; k < MB; k++) begin
      set_port(2, 1'b1, 1'b0, 32'(32'h200 + k));
      #1;
      check("t4_hold", 64'(grant), 64'h04);
      check("t4_data", 64'(bus.out_data), 64'(32'h200 + k));
      step();
    end
    check("t4_cap_grant", 64'(grant), 64'(0));
    check("t4_cap_forced", 64'(forced_release), 64'(1));
    step();
    check("t4_forced_pulse", 64'(forced_release), 64'(0));
    check("t4_grant5", 64'(grant), 64'h20);
    check("t4_data5", 64'(bus.out_data), 64'h500);
    step();
    set_port(5, 1'b0, 1'b0, 32'h0);
    check("t4_rel5", 64'(grant), 64'(0));
    step();
    check("t4_regrant2", 64'(grant), 64'h04);
    for (int k = MB; k < 20; k++) begin
      set_port(2, 1'b1, (k == 19), 32'(32'h200 + k));
      #1;
      check("t4_tail_data", 64'(bus.out_data), 64'(32'h200 + k));
      step();
    end
    set_port(2, 1'b0, 1'b0, 32'h0);
    check("t4_tail_rel", 64'(grant), 64'(0));
    check("t4_tail_forced", 64'(forced_release), 64'(0));

    // 5: out_ready pattern 1,0,0,1 on a 2-beat burst from port 4
    set_port(4, 1'b1, 1'b0, 32'h400);
    step();
    check("t5_grant", 64'(grant), 64'h10);
    begin
      logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int   b = 0;
      for (int c = 0; c < 4; c++) begin
        bus.out_ready = rdy_pat[c];
        set_port(4, 1'b1, (b == 1), 32'(32'h400 + b));
        #1;
        check("t5_hold", 64'(grant), 64'h10);
        check("t5_out_valid", 64'(bus.out_valid), 64'(1));
        check("t5_data", 64'(bus.out_data), 64'(32'h400 + b));
        check("t5_in_ready", 64'(bus.in_ready), rdy_pat[c] ? 64'h10 : 64'h0);
        step();
        if (rdy_pat[c]) b++;
      end
    end
    check("t5_rel", 64'(grant), 64'(0));
    set_port(4, 1'b0, 1'b0, 32'h0);
    bus.out_ready = 1'b1;

    // 6A: arb_en dropped mid-burst of port 0 while port 1 waits
    set_port(0, 1'b1, 1'b0, 32'h600);
    step();
    check("t6a_grant0", 64'(grant), 64'h01);
    arb_en = 1'b0;
    set_port(1, 1'b1, 1'b0, 32'h700);
    #1;
    check("t6a_data0", 64'(bus.out_data), 64'h600);
    step();
    set_port(0, 1'b1, 1'b1, 32'h601);
    #1;
    check("t6a_last0", 64'(bus.out_last), 64'(1));
    step();
    set_port(0, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      check("t6a_gated_grant", 64'(grant), 64'(0));
      check("t6a_gated_busy", 64'(busy), 64'(0));
      step();
    end
    check("t6a_gated_last", 64'(grant), 64'(0));
    arb_en = 1'b1;
    step();
    check("t6a_grant1", 64'(grant), 64'h02);

    // 6B: asynchronous reset in the middle of port 1's burst
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t6b_rst");
    check("t6b_out_id", 64'(out_id), 64'(0));
    check("t6b_forced", 64'(forced_release), 64'(0));
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b1, 32'h800);
    set_port(1, 1'b1, 1'b1, 32'h801);
    step();
    check("t6b_prio_reset", 64'(grant), 64'h01);
    check("t6b_data", 64'(bus.out_data), 64'h800);
    step();
    set_port(0, 1'b0, 1'b0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0);
    check("t6b_rel", 64'(grant), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
